// File: rtl/rst_seq_mgr.sv
// rst_seq_mgr: PLL-lock qualified reset sequencer for N_RST downstream channels.
// Ports: clk_in/rst_n_in (sync, active-low), pll_lock (async), sw_rst_req,
//        lock_lost_clr in; pll_reset_n, rst_out[N_RST], ready, lock_lost out.
module rst_seq_mgr #(
  parameter int unsigned N_RST          = 4,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 4,
  parameter int unsigned LOCK_TIMEOUT   = 200,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned STEP_CYCLES    = 4,
  parameter int unsigned LOCK_FILT      = 3
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             pll_lock,
  input  logic             sw_rst_req,
  input  logic             lock_lost_clr,
  output logic             pll_reset_n,
  output logic [N_RST-1:0] rst_out,
  output logic             ready,
  output logic             lock_lost
);

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
  localparam bit P_OK = (N_RST >= 1) && (N_RST <= 16) && (SYNC_STAGES >= 2) &&
                        (PLL_RST_CYCLES >= 1) && (LOCK_TIMEOUT >= 1) &&
                        (SETTLE_CYCLES >= 1) && (STEP_CYCLES >= 1) && (LOCK_FILT >= 1) &&
                        (PLL_RST_CYCLES <= CNT_MAX) && (LOCK_TIMEOUT <= CNT_MAX) &&
                        (SETTLE_CYCLES <= CNT_MAX) && (STEP_CYCLES <= CNT_MAX);

  if (!P_OK) begin : g_param_err
    $error("rst_seq_mgr: illegal parameter combination");
  end

  localparam int unsigned IDX_W  = (N_RST > 1) ? $clog2(N_RST) : 1;
  localparam int unsigned FILT_W = $clog2(LOCK_FILT + 1);

  localparam logic [CNT_W-1:0]  C_PLL    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  C_TO     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  C_SETTLE = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  C_STEP   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0]  C_LAST   = IDX_W'(N_RST - 1);
  localparam logic [FILT_W-1:0] C_FILT   = FILT_W'(LOCK_FILT);

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_RELEASE,
    ST_RUN
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [IDX_W-1:0]       w_idx_inc;
  logic [FILT_W-1:0]      r_filt;
  logic [FILT_W-1:0]      w_filt_nxt;
  logic [FILT_W-1:0]      w_filt_inc;
  logic                   w_loss;

  logic                   r_pll_reset_n;
  logic [N_RST-1:0]       r_rst_out;
  logic                   r_ready;
  logic                   r_lock_lost;
  logic                   w_pll_reset_n_nxt;
  logic [N_RST-1:0]       w_rst_out_nxt;
  logic                   w_ready_nxt;
  logic                   w_lock_lost_nxt;

  assign w_lock_s    = r_sync[SYNC_STAGES-1];
  assign w_idx_inc   = r_idx + 1'b1;
  assign w_filt_inc  = (r_filt == C_FILT) ? r_filt : r_filt + 1'b1;

  assign pll_reset_n = r_pll_reset_n;
  assign rst_out     = r_rst_out;
  assign ready       = r_ready;
  assign lock_lost   = r_lock_lost;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_sync        <= '0;
      r_state       <= ST_PLL_RST;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_filt        <= '0;
      r_pll_reset_n <= 1'b0;
      r_rst_out     <= '1;
      r_ready       <= 1'b0;
      r_lock_lost   <= 1'b0;
    end else begin
      r_sync        <= {r_sync[SYNC_STAGES-2:0], pll_lock};
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_idx         <= w_idx_nxt;
      r_filt        <= w_filt_nxt;
      r_pll_reset_n <= w_pll_reset_n_nxt;
      r_rst_out     <= w_rst_out_nxt;
      r_ready       <= w_ready_nxt;
      r_lock_lost   <= w_lock_lost_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_filt_nxt  = '0;
    w_loss      = 1'b0;
    unique case (r_state)
      ST_PLL_RST: begin
        if (r_cnt == C_PLL) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_TO) begin
          w_state_nxt = ST_PLL_RST;
          w_cnt_nxt   = '0;
        end
      end
      ST_SETTLE: begin
        if (!w_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_SETTLE) begin
          w_state_nxt = (N_RST == 1) ? ST_RUN : ST_RELEASE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      end
      ST_RELEASE, ST_RUN: begin
        // Priority: filtered lock loss, then software request, then sequencing.
        if (!w_lock_s) begin
          w_filt_nxt = w_filt_inc;
        end
        if (!w_lock_s && (w_filt_inc == C_FILT)) begin
          w_loss      = 1'b1;
          w_filt_nxt  = '0;
          w_state_nxt = ST_PLL_RST;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else if (sw_rst_req) begin
          w_filt_nxt  = '0;
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else if (r_state == ST_RELEASE) begin
          if (r_cnt == C_STEP) begin
            w_cnt_nxt = '0;
            w_idx_nxt = w_idx_inc;
            if (w_idx_inc == C_LAST) begin
              w_state_nxt = ST_RUN;
            end
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_PLL_RST;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    w_pll_reset_n_nxt = (w_state_nxt != ST_PLL_RST);
    w_ready_nxt       = (w_state_nxt == ST_RUN);
    w_rst_out_nxt     = '1;
    if (w_state_nxt == ST_RUN) begin
      w_rst_out_nxt = '0;
    end else if (w_state_nxt == ST_RELEASE) begin
      for (int unsigned i = 0; i < N_RST; i++) begin
        if (IDX_W'(i) <= w_idx_nxt) begin
          w_rst_out_nxt[i] = 1'b0;
        end
      end
    end
    if (w_loss) begin
      w_lock_lost_nxt = 1'b1;
    end else if (lock_lost_clr) begin
      w_lock_lost_nxt = 1'b0;
    end else begin
      w_lock_lost_nxt = r_lock_lost;
    end
  end

endmodule
